alt_vipcti131_common_timing_decoder: RTL

ALT_VIPCTI131_COMMON_TIMING_DECODER -- requirements
Module: alt_vipcti131_common_timing_decoder

---
 rtl/alt_vipcti131_common_timing_decoder_pkg.sv | 21 ++
 rtl/alt_vipcti131_common_window_compare.sv | 27 ++
 rtl/alt_vipcti131_common_timing_decoder.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/alt_vipcti131_common_timing_decoder_pkg.sv
// Shared timing widths and the bound-set record
// used by the common timing decoder.
package alt_vipcti131_common_timing_decoder_pkg;

  localparam int H_W = 14;
  localparam int V_W = 13;

  typedef struct packed {
    logic [H_W-1:0] h_sync_start;
    logic [H_W-1:0] h_sync_end;
    logic [H_W-1:0] h_active_start;
    logic [H_W-1:0] h_active_end;
    logic [V_W-1:0] v_sync_start;
    logic [V_W-1:0] v_sync_end;
    logic [V_W-1:0] v_active_start;
    logic [V_W-1:0] v_active_end;
    logic           h_sync_inv;
    logic           v_sync_inv;
  } bounds_t;

endpackage

// File: rtl/alt_vipcti131_common_window_compare.sv
// Half-open window test with wrap-around;
// an empty window (start == end) never matches.
module alt_vipcti131_common_window_compare #(
  parameter int W = 14
) (
  input  logic [W-1:0] i_count,
  input  logic [W-1:0] i_start,
  input  logic [W-1:0] i_end,
  output logic         o_in_window
);

  logic w_ge_start;
  logic w_lt_end;

  assign w_ge_start = (i_count >= i_start);
  assign w_lt_end   = (i_count < i_end);

  // Plain range, wrapped range, or empty.
  always_comb begin
    o_in_window = 1'b0;
    if (i_start < i_end)
      o_in_window = w_ge_start & w_lt_end;
    else if (i_start > i_end)
      o_in_window = w_ge_start | w_lt_end;
  end

endmodule

// File: rtl/alt_vipcti131_common_timing_decoder.sv
// Turns frame-counter positions into registered
// sync/blank/de, with frame-aligned mode updates.
module alt_vipcti131_common_timing_decoder
  import alt_vipcti131_common_timing_decoder_pkg::*;
#(
  parameter int LOG2_NUMBER_OF_COLOUR_PLANES = 1,
  parameter int REGISTER_MODE_ON_FRAME       = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  input  logic           start_of_sample,
  input  logic           new_line,
  input  logic [H_W-1:0] h_count,
  input  logic [V_W-1:0] v_count,
  input  logic [H_W-1:0] h_sync_start,
  input  logic [H_W-1:0] h_sync_end,
  input  logic [H_W-1:0] h_active_start,
  input  logic [H_W-1:0] h_active_end,
  input  logic [V_W-1:0] v_sync_start,
  input  logic [V_W-1:0] v_sync_end,
  input  logic [V_W-1:0] v_active_start,
  input  logic [V_W-1:0] v_active_end,
  input  logic           h_sync_inv,
  input  logic           v_sync_inv,
  input  logic           mode_valid,
  output logic           h_sync,
  output logic           v_sync,
  output logic           h_blank,
  output logic           v_blank,
  output logic           de,
  output logic           start_of_frame,
  output logic           mode_applied,
  output logic           mode_pending
);

  localparam bit ON_FRAME = (REGISTER_MODE_ON_FRAME != 0);

  bounds_t r_active;
  bounds_t r_pending;
  bounds_t w_in;
  bounds_t w_eval;

  logic r_h_sync, r_v_sync, r_h_blank, r_v_blank, r_de;
  logic r_sof, r_mode_applied, r_mode_pending;
  logic w_boundary, w_apply;
  logic w_hs_win, w_vs_win, w_ha_win, w_va_win;
  logic w_unused;

  // new_line and the plane count carry no timing meaning here.
  assign w_unused = new_line ^ (LOG2_NUMBER_OF_COLOUR_PLANES > 0);

  assign w_in = '{
    h_sync_start:   h_sync_start,
    h_sync_end:     h_sync_end,
    h_active_start: h_active_start,
    h_active_end:   h_active_end,
    v_sync_start:   v_sync_start,
    v_sync_end:     v_sync_end,
    v_active_start: v_active_start,
    v_active_end:   v_active_end,
    h_sync_inv:     h_sync_inv,
    v_sync_inv:     v_sync_inv
  };

  assign w_boundary = enable & start_of_sample
                    & (h_count == '0) & (v_count == '0);

  // The boundary that applies a pending set also evaluates with it.
  assign w_apply = ON_FRAME & w_boundary & r_mode_pending;
  assign w_eval  = w_apply ? r_pending : r_active;

  alt_vipcti131_common_window_compare #(.W(H_W)) u_hs (
    .i_count(h_count), .i_start(w_eval.h_sync_start),
    .i_end(w_eval.h_sync_end), .o_in_window(w_hs_win));

  alt_vipcti131_common_window_compare #(.W(H_W)) u_ha (
    .i_count(h_count), .i_start(w_eval.h_active_start),
    .i_end(w_eval.h_active_end), .o_in_window(w_ha_win));

  alt_vipcti131_common_window_compare #(.W(V_W)) u_vs (
    .i_count(v_count), .i_start(w_eval.v_sync_start),
    .i_end(w_eval.v_sync_end), .o_in_window(w_vs_win));

  alt_vipcti131_common_window_compare #(.W(V_W)) u_va (
    .i_count(v_count), .i_start(w_eval.v_active_start),
    .i_end(w_eval.v_active_end), .o_in_window(w_va_win));

  // Bound-set bookkeeping: capture, apply, and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_active       <= '0;
      r_pending      <= '0;
      r_mode_pending <= 1'b0;
      r_mode_applied <= 1'b0;
      r_sof          <= 1'b0;
    end else begin
      r_sof          <= w_boundary;
      r_mode_applied <= 1'b0;
      if (ON_FRAME) begin
        if (w_apply) begin
          r_active       <= r_pending;
          r_mode_pending <= 1'b0;
          r_mode_applied <= 1'b1;
        end
        if (mode_valid) begin
          r_pending      <= w_in;
          r_mode_pending <= 1'b1;
        end
      end else if (mode_valid) begin
        r_active       <= w_in;
        r_mode_applied <= 1'b1;
      end
    end
  end

  // Timing outputs advance only on enabled cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_h_sync  <= 1'b0;
      r_v_sync  <= 1'b0;
      r_h_blank <= 1'b1;
      r_v_blank <= 1'b1;
      r_de      <= 1'b0;
    end else if (enable) begin
      r_h_sync  <= w_hs_win ^ w_eval.h_sync_inv;
      r_v_sync  <= w_vs_win ^ w_eval.v_sync_inv;
      r_h_blank <= ~w_ha_win;
      r_v_blank <= ~w_va_win;
      r_de      <= w_ha_win & w_va_win;
    end
  end

  assign h_sync         = r_h_sync;
  assign v_sync         = r_v_sync;
  assign h_blank        = r_h_blank;
  assign v_blank        = r_v_blank;
  assign de             = r_de;
  assign start_of_frame = r_sof;
  assign mode_applied   = r_mode_applied;
  assign mode_pending   = r_mode_pending;

endmodule
